prog_fsm_core: RTL

Parametrised, table-programmable synchronous state machine for the control/benchmark sequential blocks. Each enabled cycle, the block maps the current state and input symbol to a next state and a registered output word through a writable transition table. It generalises the fixed 3-state-bit, 3-input, 4-output gate-level controllers to arbitrary widths with run-time programming, hold, soft restart and an optional stuck-state watchdog. It sits between the input sampler and the output register bank.

---
 rtl/prog_fsm_core_if.sv | 28 ++
 rtl/prog_fsm_core.sv | 112 +++++++++++
 2 files changed

// File: rtl/prog_fsm_core_if.sv
// Step/config/status bundle for prog_fsm_core.
// master drives stimulus and programming; slave is the FSM core.
interface prog_fsm_core_if #(
    parameter int unsigned IW = 3,
    parameter int unsigned SW = 3,
    parameter int unsigned OW = 4
) ();
    logic              en;
    logic              restart;
    logic [IW-1:0]     in;
    logic              cfg_we;
    logic [SW+IW-1:0]  cfg_addr;
    logic [SW+OW-1:0]  cfg_wdata;
    logic [SW-1:0]     state;
    logic [OW-1:0]     out;
    logic              cfg_err;
    logic              wdog_trip;

    modport master (
        output en, restart, in, cfg_we, cfg_addr, cfg_wdata,
        input  state, out, cfg_err, wdog_trip
    );

    modport slave (
        input  en, restart, in, cfg_we, cfg_addr, cfg_wdata,
        output state, out, cfg_err, wdog_trip
    );
endinterface

// File: rtl/prog_fsm_core.sv
// Table-programmable synchronous state machine: {state,in} indexes a writable table of
// {next_state,out}. Optional stuck-state watchdog is built when PFSM_WDOG_EN is defined.
module prog_fsm_core #(
    parameter int unsigned      IW          = 3,
    parameter int unsigned      SW          = 3,
    parameter int unsigned      OW          = 4,
    parameter logic [SW-1:0]    RESET_STATE = '0,
    parameter int unsigned      WDOG_LIMIT  = 15
) (
    input  logic                clk,
    input  logic                rst,
    prog_fsm_core_if.slave      bus
);
    localparam int unsigned AW    = SW + IW;
    localparam int unsigned DW    = SW + OW;
    localparam int unsigned Depth = 2 ** AW;

    if (WDOG_LIMIT < 1 || WDOG_LIMIT > 255) begin : g_bad_limit
        $error("WDOG_LIMIT must be in 1..255");
    end

    logic [DW-1:0] mem_q [Depth];

    logic [SW-1:0] state_q, state_d;
    logic [OW-1:0] out_q, out_d;
    logic          cfg_err_q, cfg_err_d;
    logic          wdog_trip_q, wdog_trip_d;

    logic [DW-1:0] entry;
    logic [SW-1:0] entry_state;
    logic [OW-1:0] entry_out;
    logic          cfg_wr;
    logic          trip;

    // Lookup sees the table as it stood before any write at this edge.
    assign entry       = mem_q[{state_q, bus.in}];
    assign entry_state = entry[DW-1:OW];
    assign entry_out   = entry[OW-1:0];

    assign cfg_wr    = bus.cfg_we & ~bus.en;
    assign cfg_err_d = cfg_err_q | (bus.cfg_we & bus.en);

`ifdef PFSM_WDOG_EN
    logic [7:0] cnt_q, cnt_d;
    logic       self_loop;

    assign self_loop = (entry_state == state_q);
    // A self-loop step arriving with the count already at the limit becomes a trip.
    assign trip = bus.en & ~bus.restart & self_loop & (cnt_q == WDOG_LIMIT[7:0]);

    always_comb begin
        cnt_d = cnt_q;
        if (bus.restart || trip) begin
            cnt_d = '0;
        end else if (bus.en) begin
            cnt_d = self_loop ? cnt_q + 8'd1 : 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign trip = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        wdog_trip_d = trip;
        if (bus.restart || trip) begin
            state_d = RESET_STATE;
            out_d   = '0;
        end else if (bus.en) begin
            state_d = entry_state;
            out_d   = entry_out;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RESET_STATE;
            out_q       <= '0;
            cfg_err_q   <= 1'b0;
            wdog_trip_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            cfg_err_q   <= cfg_err_d;
            wdog_trip_q <= wdog_trip_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (cfg_wr) begin
            mem_q[bus.cfg_addr] <= bus.cfg_wdata;
        end
    end

    assign bus.state     = state_q;
    assign bus.out       = out_q;
    assign bus.cfg_err   = cfg_err_q;
    assign bus.wdog_trip = wdog_trip_q;
endmodule
